// File: rtl/mult_sequencer.sv
// Iterative shift-add multiplier with stall/done control beside the ALU.
// Ports: clk, rst_n, start, signed_op, abort, op_a, op_b -> busy, stall, done, hi, lo.
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     p_q, p_d;
  logic [WIDTH-1:0]  ma_q, ma_d;
  logic              neg_q, neg_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;

  logic              sign_a, sign_b;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [WIDTH:0]    sum;
  logic [PW-1:0]     p_fix;

  assign sign_a = signed_op & op_a[WIDTH-1];
  assign sign_b = signed_op & op_b[WIDTH-1];
  assign mag_a  = sign_a ? -op_a : op_a;
  assign mag_b  = sign_b ? -op_b : op_b;

  // Upper half plus optional addend, one extra bit keeps the carry.
  assign sum   = {1'b0, p_q[PW-1:WIDTH]}
               + (p_q[0] ? {1'b0, ma_q} : {(WIDTH+1){1'b0}});
  assign p_fix = neg_q ? -p_q : p_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    p_d     = p_q;
    ma_d    = ma_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          count_d = '0;
          ma_d    = mag_a;
          neg_d   = sign_a ^ sign_b;
          p_d     = {{WIDTH{1'b0}}, mag_b};
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          p_d     = {sum, p_q[WIDTH-1:1]};
          count_d = count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!abort) begin
          p_d    = p_fix;
          hi_d   = p_fix[PW-1:WIDTH];
          lo_d   = p_fix[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      p_q     <= '0;
      ma_q    <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_q     <= p_d;
      ma_q    <= ma_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign stall = (start & ~abort) | busy;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: products, latency, stall, abort, reset.
// Expected products come from a 64-bit reference multiply.
module tb_mult_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic        abort;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_bad;
  logic [63:0] exp_q[$];
  logic [63:0] last_res;

  mult_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op (signed_op),
    .abort     (abort),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic s);
    logic [63:0] xa;
    logic [63:0] xb;
    xa = s ? {{32{a[31]}}, a} : {32'h0, a};
    xb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return xa * xb;
  endfunction

  // Scoreboard side: every done pops one expected product.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("product", {hi, lo}, e);
        last_res = e;
      end
    end
  end

  // Drives one op from the current negedge (T0). Returns at the done
  // negedge, or after the abort has settled when abort_at > 0.
  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic        s,
                        input int          repulse_at,
                        input int          abort_at,
                        input int          hold_at,
                        input logic [63:0] hold_val);
    int n;
    int bad;
    bit got_done;
    n = 0;
    bad = 0;
    got_done = 0;
    start = 1'b1;
    abort = 1'b0;
    op_a = a;
    op_b = b;
    signed_op = s;
    if (abort_at <= 0) exp_q.push_back(model(a, b, s));
    #1;
    chk("stall_t0", {63'd0, stall}, 64'd1);
    while (n < 100 && !got_done) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      start = 1'b0;
      abort = 1'b0;
      if (abort_at > 0 && n == abort_at + 1) begin
        chk("abort_idle", {63'd0, busy}, 64'd0);
        chk("abort_keep", {hi, lo}, hold_val);
        for (int i = 0; i < 40; i++) @(negedge clk);
        chk("abort_after", {hi, lo}, hold_val);
        return;
      end
      if (done) begin
        got_done = 1;
        chk("latency", 64'(n), 64'd34);
        chk("busy_done", {63'd0, busy}, 64'd0);
      end else begin
        if (busy !== 1'b1) bad++;
        if (stall !== 1'b1) bad++;
        if (n == repulse_at) begin
          start = 1'b1;
          op_a = 32'h1234_5678;
          op_b = 32'h9;
        end
        if (n == abort_at) abort = 1'b1;
        if (n == hold_at) chk("hold_prev", {hi, lo}, hold_val);
      end
    end
    if (!got_done) chk("timeout", 64'd1, 64'd0);
    chk("busy_stall_window", 64'(bad), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_res = '0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    signed_op = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 0, 0, 0, 0);
    chk("neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    // Reset in the middle of a run wipes everything immediately.
    start = 1'b1;
    op_a = 32'd100;
    op_b = 32'd100;
    signed_op = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", {63'd0, busy}, 64'd0);
    chk("midrun_rst_done", {63'd0, done}, 64'd0);
    chk("midrun_rst_hilo", {hi, lo}, 64'd0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd7, 32'd6, 1'b0, 0, 0, 0, 0);
    chk("7x6", {hi, lo}, 64'h0000_0000_0000_002A);

    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, 0, 0);
    chk("minxmin", {hi, lo}, 64'h4000_0000_0000_0000);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, 0);
    chk("ffu", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 10, 0, 0, 0);
    chk("ffs_repulse", {hi, lo}, 64'h0000_0000_0000_0001);

    // Back-to-back: start in the done cycle, previous result held.
    run_op(32'd2, 32'd3, 1'b0, 0, 0, 20, 64'h1);
    chk("2x3", {hi, lo}, 64'h6);

    for (int k = 0; k < 4; k++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      run_op(ra, rb, k[0], 0, 0, 0, 0);
    end

    // Abort mid-run keeps the last result.
    @(negedge clk);
    run_op(32'd11, 32'd13, 1'b0, 0, 15, 0, last_res);

    // Start with abort in IDLE is dropped.
    start = 1'b1;
    abort = 1'b1;
    op_a = 32'd9;
    op_b = 32'd9;
    #1;
    chk("abort_start_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
